// File: rtl/reg_op_sequencer.sv
// -----------------------------------------------------------------------------
// reg_op_sequencer
//
// Purpose:
//    Initiator side of a small register file's read/write port. Accepts one
//    MIPS R-type instruction per valid/ready handshake, presents the source
//    register addresses to the register file, consumes the read data that
//    returns one clock later, runs the ALU operation and writes the result
//    back. One instruction is in flight at a time:
//       IDLE -> READ -> EXEC -> WB -> IDLE
//    An illegal instruction leaves READ straight for IDLE with an Err pulse.
//
// Parameters:
//    DATA_W       register / data width
//    ADDR_W       register address width (low ADDR_W bits of rs/rt/rd used)
//
// Ports:
//    Clk          clock, all state updates on the rising edge
//    Reset        synchronous, active-high reset
//    InstrValid   instruction source has an instruction this cycle
//    Instruction  R-type word: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0]
//    InstrReady   sequencer accepts an instruction this cycle
//    ReadReg1     register file read address 1 (rs of the held instruction)
//    ReadReg2     register file read address 2 (rt of the held instruction)
//    ReadData1    register file data 1, valid one clock after ReadReg1
//    ReadData2    register file data 2, same timing as ReadData1
//    RegWrite     register file write enable
//    WriteReg     register file write address (rd of the held instruction)
//    WriteData    registered ALU result
//    Done         one-cycle pulse: instruction written back
//    Err          one-cycle pulse: instruction rejected as illegal
// -----------------------------------------------------------------------------
module reg_op_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InstrValid,
   input  logic [31:0]       Instruction,
   output logic              InstrReady,
   output logic [ADDR_W-1:0] ReadReg1,
   output logic [ADDR_W-1:0] ReadReg2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              Done,
   output logic              Err
);

   // Supported R-type function codes
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   // Bit positions of the register fields inside the instruction word
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         ir_q,    ir_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                done_q,  done_d;
   logic                err_q,   err_d;

   // Only part of the instruction word is decoded (shamt and the upper bits
   // of the register fields are don't-care); this sink keeps that explicit.
   logic                unused_ir_s;

   // ---------------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------------

   // Legal means R-type opcode and one of the five implemented functions.
   function automatic logic is_legal(input logic [31:0] instr);
      logic legal;
      if (instr[31:26] != 6'd0) begin
         legal = 1'b0;
      end else begin
         case (instr[5:0])
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: legal = 1'b1;
            default:                                             legal = 1'b0;
         endcase
      end
      return legal;
   endfunction

   // ALU: add/sub wrap silently; slt is a signed compare, zero-extended.
   function automatic logic [DATA_W-1:0] alu_result(
      input logic [5:0]        funct,
      input logic [DATA_W-1:0] op_a,
      input logic [DATA_W-1:0] op_b
   );
      logic [DATA_W-1:0] res;
      case (funct)
         FUNCT_ADD: res = op_a + op_b;
         FUNCT_SUB: res = op_a - op_b;
         FUNCT_AND: res = op_a & op_b;
         FUNCT_OR:  res = op_a | op_b;
         FUNCT_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default:   res = {DATA_W{1'b0}};
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------

   // Sequencer next state, instruction capture, result and status pulses.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // InstrReady is high whenever we are here and Reset is low;
            // Reset is handled in the register block, so only valid matters.
            if (InstrValid) begin
               ir_d    = Instruction;
               state_d = S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_READ: begin
            // Register file samples ReadReg1/2 at the end of this cycle.
            if (is_legal(ir_q)) begin
               state_d = S_EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_EXEC: begin
            // Read data is only guaranteed valid in this cycle, so the result
            // is captured here and held stable through WB.
            wdata_d = alu_result(ir_q[5:0], ReadData1, ReadData2);
            done_d  = 1'b1;
            state_d = S_WB;
         end

         S_WB: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------

   // Sequencer state and registered outputs with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         ir_q    <= 32'd0;
         wdata_q <= {DATA_W{1'b0}};
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------

   // Addresses come straight from the held instruction so they stay stable
   // from READ through WB without extra registers.
   assign ReadReg1  = ir_q[RS_LSB +: ADDR_W];
   assign ReadReg2  = ir_q[RT_LSB +: ADDR_W];
   assign WriteReg  = ir_q[RD_LSB +: ADDR_W];
   assign WriteData = wdata_q;
   assign Err       = err_q;

   // Reset gates the handshake and the write strobe immediately so that an
   // instruction caught mid-flight is dropped without touching the register
   // file. Done is gated the same way: no write, no completion.
   assign InstrReady = (state_q == S_IDLE) && !Reset;
   assign RegWrite   = (state_q == S_WB)   && !Reset;
   assign Done       = done_q              && !Reset;

   assign unused_ir_s = ^ir_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_op_sequencer
//
// Self-checking bench for reg_op_sequencer. A behavioural 4-entry register
// file sits on the DUT's port; a separate architectural register array is
// updated from the instruction semantics and used to predict every result.
// -----------------------------------------------------------------------------
module tb_reg_op_sequencer;

   logic        Clk;
   logic        Reset;
   logic        InstrValid;
   logic [31:0] Instruction;
   logic        InstrReady;
   logic [1:0]  ReadReg1;
   logic [1:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        RegWrite;
   logic [1:0]  WriteReg;
   logic [31:0] WriteData;
   logic        Done;
   logic        Err;

   int n_tests;
   int n_fail;

   // Register file attached to the DUT port and its reset-loading control
   logic [31:0] rf [4];
   logic        rf_init;

   // Architectural reference registers
   logic [31:0] ref_rf [4];

   reg_op_sequencer #(.DATA_W(32), .ADDR_W(2)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .InstrValid  (InstrValid),
      .Instruction (Instruction),
      .InstrReady  (InstrReady),
      .ReadReg1    (ReadReg1),
      .ReadReg2    (ReadReg2),
      .ReadData1   (ReadData1),
      .ReadData2   (ReadData2),
      .RegWrite    (RegWrite),
      .WriteReg    (WriteReg),
      .WriteData   (WriteData),
      .Done        (Done),
      .Err         (Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file: registered read (one clock latency), write at edge.
   always @(posedge Clk) begin
      if (rf_init) begin
         for (int i = 0; i < 4; i++) rf[i] <= 32'(i + 1);
      end else if (RegWrite) begin
         rf[WriteReg] <= WriteData;
      end
      ReadData1 <= rf[ReadReg1];
      ReadData2 <= rf[ReadReg2];
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_legal(input logic [31:0] instr);
      logic [5:0] f;
      f = instr[5:0];
      return (instr[31:26] == 6'd0) &&
             (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
   endfunction

   function automatic logic [31:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      case (f)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Full reset with register file reload; checks the reset output state.
   task automatic do_reset();
      Reset       = 1'b1;
      rf_init     = 1'b1;
      InstrValid  = 1'b0;
      Instruction = 32'd0;
      repeat (2) @(posedge Clk);
      #1;
      chk_eq("rst_ready",  {31'd0, InstrReady}, 32'd0);
      chk_eq("rst_regwr",  {31'd0, RegWrite},   32'd0);
      chk_eq("rst_done",   {31'd0, Done},       32'd0);
      chk_eq("rst_err",    {31'd0, Err},        32'd0);
      chk_eq("rst_wdata",  WriteData,           32'd0);
      chk_eq("rst_wreg",   {30'd0, WriteReg},   32'd0);
      chk_eq("rst_rreg1",  {30'd0, ReadReg1},   32'd0);
      chk_eq("rst_rreg2",  {30'd0, ReadReg2},   32'd0);
      Reset   = 1'b0;
      rf_init = 1'b0;
      for (int i = 0; i < 4; i++) ref_rf[i] = 32'(i + 1);
      #1;
      chk_eq("rst_rel_ready", {31'd0, InstrReady}, 32'd1);
   endtask

   // Offer one instruction, follow it cycle by cycle. Legal instructions end
   // at the WB sample point, illegal ones at the Err sample point.
   // hold_valid keeps InstrValid high with junk Instruction after accept.
   task automatic run_instr(input logic [31:0] instr, input bit hold_valid);
      int          waited;
      logic        legal;
      logic [1:0]  rs, rt, rd;
      logic [31:0] exp_res;
      logic [31:0] junk;
      legal   = ref_legal(instr);
      rs      = instr[22:21];
      rt      = instr[17:16];
      rd      = instr[12:11];
      exp_res = ref_op(instr[5:0], ref_rf[rs], ref_rf[rt]);

      InstrValid  = 1'b1;
      Instruction = instr;
      waited      = 0;
      while (!InstrReady && waited < 8) begin
         @(posedge Clk); #1;
         waited++;
      end
      chk_eq("accept_ready", {31'd0, InstrReady}, 32'd1);

      @(posedge Clk); #1;   // READ
      junk = $urandom();
      if (hold_valid) Instruction = junk;
      else            InstrValid  = 1'b0;
      chk_eq("read_ready", {31'd0, InstrReady}, 32'd0);
      chk_eq("read_regwr", {31'd0, RegWrite},   32'd0);
      chk_eq("read_done",  {31'd0, Done},       32'd0);
      chk_eq("read_err",   {31'd0, Err},        32'd0);
      chk_eq("read_rreg1", {30'd0, ReadReg1},   {30'd0, rs});
      chk_eq("read_rreg2", {30'd0, ReadReg2},   {30'd0, rt});

      @(posedge Clk); #1;
      if (!legal) begin
         chk_eq("ill_err",   {31'd0, Err},        32'd1);
         chk_eq("ill_ready", {31'd0, InstrReady}, 32'd1);
         chk_eq("ill_regwr", {31'd0, RegWrite},   32'd0);
         chk_eq("ill_done",  {31'd0, Done},       32'd0);
      end else begin
         // EXEC
         chk_eq("exec_regwr", {31'd0, RegWrite},   32'd0);
         chk_eq("exec_done",  {31'd0, Done},       32'd0);
         chk_eq("exec_ready", {31'd0, InstrReady}, 32'd0);
         junk = $urandom();
         if (hold_valid) Instruction = junk;
         @(posedge Clk); #1;   // WB
         chk_eq("wb_regwr", {31'd0, RegWrite},   32'd1);
         chk_eq("wb_done",  {31'd0, Done},       32'd1);
         chk_eq("wb_ready", {31'd0, InstrReady}, 32'd0);
         chk_eq("wb_wreg",  {30'd0, WriteReg},   {30'd0, rd});
         chk_eq("wb_wdata", WriteData,           exp_res);
         ref_rf[rd] = exp_res;
      end
   endtask

   // Reset while an add is in EXEC (stage 2) or WB (stage 3).
   task automatic reset_mid(input int stage);
      int waited;
      InstrValid  = 1'b1;
      Instruction = 32'h00221820;
      waited      = 0;
      while (!InstrReady && waited < 8) begin
         @(posedge Clk); #1;
         waited++;
      end
      chk_eq("rm_accept", {31'd0, InstrReady}, 32'd1);
      @(posedge Clk); #1;   // READ
      InstrValid = 1'b0;
      repeat (stage - 1) begin
         @(posedge Clk); #1;
      end
      Reset = 1'b1;
      #1;
      chk_eq("rm_regwr", {31'd0, RegWrite},   32'd0);
      chk_eq("rm_done",  {31'd0, Done},       32'd0);
      chk_eq("rm_ready", {31'd0, InstrReady}, 32'd0);
      @(posedge Clk); #1;
      chk_eq("rm2_regwr", {31'd0, RegWrite}, 32'd0);
      chk_eq("rm2_done",  {31'd0, Done},     32'd0);
      chk_eq("rm2_wdata", WriteData,         32'd0);
      chk_eq("rm2_wreg",  {30'd0, WriteReg}, 32'd0);
      Reset = 1'b0;
      #1;
      chk_eq("rm_rel_ready", {31'd0, InstrReady}, 32'd1);
      @(posedge Clk); #1;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) chk_eq(tag, rf[i], ref_rf[i]);
   endtask

   initial begin
      int          acc, wr, er;
      logic [31:0] instr, junk;
      logic [5:0]  op, funct;
      n_tests = 0;
      n_fail  = 0;

      do_reset();

      // Basic add, then sub to r0 and a signed slt on the negative result
      run_instr(32'h00221820, 1'b0);
      chk_eq("add_r3_is_5", WriteData, 32'd5);
      run_instr(32'h00220022, 1'b0);
      chk_eq("sub_neg1", WriteData, 32'hFFFF_FFFF);
      run_instr(32'h00020A2A, 1'b0);
      chk_eq("slt_signed", WriteData, 32'd1);

      // Dependent pair, second offered during WB of the first
      do_reset();
      run_instr(32'h00221820, 1'b0);
      run_instr(32'h00630020, 1'b0);
      chk_eq("dep_r3_plus_r3", WriteData, 32'd10);

      // Illegal opcode and unsupported funct
      run_instr(32'h8C220000, 1'b0);
      run_instr(32'h00220027, 1'b0);
      InstrValid = 1'b0;
      @(posedge Clk); #1;
      check_regs("regs_after_dir");

      // Reset in EXEC, then in WB: nothing written
      reset_mid(2);
      reset_mid(3);
      check_regs("regs_after_rst");

      // InstrValid held high: one accept per 4 cycles, junk never captured
      acc = 0; wr = 0; er = 0;
      chk_eq("hold_start_ready", {31'd0, InstrReady}, 32'd1);
      for (int c = 0; c < 16; c++) begin
         InstrValid = 1'b1;
         if (InstrReady) begin
            acc++;
            Instruction = 32'h00000024;
         end else begin
            junk        = $urandom();
            Instruction = {6'h23, junk[25:0]};
         end
         if (RegWrite) wr++;
         if (Err)      er++;
         @(posedge Clk); #1;
      end
      InstrValid = 1'b0;
      chk_eq("hold_accepts", 32'(acc), 32'd4);
      chk_eq("hold_writes",  32'(wr),  32'd4);
      chk_eq("hold_errs",    32'(er),  32'd0);

      // Randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(1, 63));
         else                           op = 6'd0;
         case ($urandom_range(0, 5))
            0:       funct = 6'h20;
            1:       funct = 6'h22;
            2:       funct = 6'h24;
            3:       funct = 6'h25;
            4:       funct = 6'h2A;
            default: funct = 6'($urandom_range(0, 63));
         endcase
         junk  = $urandom();
         instr = {op, junk[25:6], funct};
         if ($urandom_range(0, 3) == 0) begin
            InstrValid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge Clk); #1;
            end
         end
         run_instr(instr, 1'($urandom_range(0, 1)));
      end
      InstrValid = 1'b0;
      repeat (2) begin
         @(posedge Clk); #1;
      end
      check_regs("regs_final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
